// File: rtl/fetch_decode_unit_if.sv
// Fetch/decode bus: the ROM address, the fetched word, execute-side
// control (stall/redirect) and the decoded instruction fields and flags.
// The master side is the fetch/decode unit; the slave side is the
// environment (instruction ROM and execute stage).
interface fetch_decode_unit_if;
  logic [15:0] pc;
  logic [8:0]  instruction;
  logic        stall;
  logic        redirect;
  logic [15:0] redirect_pc;
  logic [4:0]  opcode;
  logic [3:0]  operand;
  logic        dec_valid;
  logic        is_branch;
  logic        is_mem;
  logic        halted;
  logic        illegal;

  modport master (
    output pc, opcode, operand, dec_valid, is_branch, is_mem, halted, illegal,
    input  instruction, stall, redirect, redirect_pc
  );

  modport slave (
    input  pc, opcode, operand, dec_valid, is_branch, is_mem, halted, illegal,
    output instruction, stall, redirect, redirect_pc
  );
endinterface

// File: rtl/fetch_decode_unit.sv
// Fetch/decode unit: drives the instruction ROM address, registers the
// returned 9-bit word one cycle later and decodes it into opcode/operand
// plus branch/memory/illegal flags. A retired halt stops fetch until reset.
// Optional feature macro: FDU_ILLEGAL_TRAP_EN -- when defined, an illegal
// opcode (5'b11011..5'b11111) retires like halt and latches illegal until
// reset; when undefined, illegal opcodes pass as no-ops and illegal is 0.
module fetch_decode_unit #(
  parameter logic [15:0] RESET_PC = 16'd1
) (
  input logic                 clk,
  input logic                 rst_n,
  fetch_decode_unit_if.master bus
);

  localparam logic [4:0] OP_HALT = 5'b11010;

  typedef enum logic [1:0] {
    START  = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2
  } state_t;

  // Conditional branches occupy 5'b01111..5'b10011; 5'b11000 is jump.
  function automatic logic op_is_branch(input logic [4:0] op);
    return ((op >= 5'b01111) && (op <= 5'b10011)) || (op == 5'b11000);
  endfunction

  // ld (5'b10110) and st (5'b10111).
  function automatic logic op_is_mem(input logic [4:0] op);
    return (op == 5'b10110) || (op == 5'b10111);
  endfunction

  // Top five encodings are unassigned.
  function automatic logic op_is_illegal(input logic [4:0] op);
    return (op >= 5'b11011);
  endfunction

  // Opcodes that end fetch once retired.
  function automatic logic op_stops_fetch(input logic [4:0] op);
`ifdef FDU_ILLEGAL_TRAP_EN
    return (op == OP_HALT) || op_is_illegal(op);
`else
    return (op == OP_HALT);
`endif
  endfunction

  state_t      state_r, state_s;
  logic [15:0] pc_r, pc_s;
  logic [8:0]  dec_r, dec_s;
  logic        dec_valid_r, dec_valid_s;
  logic        halted_r, halted_s;
  logic        retire_stop_s;
  logic        fetch_stop_s;

  // A stopping opcode is live in decode and is retired this cycle unless flushed.
  assign retire_stop_s = dec_valid_r && op_stops_fetch(dec_r[8:4]);
  // The word being fetched now is a stopping opcode, so pc must not advance.
  assign fetch_stop_s  = op_stops_fetch(bus.instruction[8:4]);

`ifdef FDU_ILLEGAL_TRAP_EN
  logic trap_r, trap_s;
`endif

  // Next-state and next-register computation for the fetch FSM.
  always_comb begin
    state_s     = state_r;
    pc_s        = pc_r;
    dec_s       = dec_r;
    dec_valid_s = dec_valid_r;
    halted_s    = halted_r;
`ifdef FDU_ILLEGAL_TRAP_EN
    trap_s      = trap_r;
`endif
    case (state_r)
      START: begin
        pc_s        = RESET_PC;
        dec_valid_s = 1'b0;
        halted_s    = 1'b0;
        state_s     = RUN;
      end
      RUN: begin
        if (bus.redirect) begin
          // Flush: the word at the old pc is dropped, a pending halt is squashed.
          pc_s        = bus.redirect_pc;
          dec_valid_s = 1'b0;
        end else if (bus.stall) begin
          pc_s        = pc_r;
          dec_valid_s = dec_valid_r;
        end else if (retire_stop_s) begin
          state_s     = HALTED;
          dec_valid_s = 1'b0;
          halted_s    = 1'b1;
`ifdef FDU_ILLEGAL_TRAP_EN
          trap_s      = trap_r | op_is_illegal(dec_r[8:4]);
`endif
        end else begin
          dec_s       = bus.instruction;
          dec_valid_s = 1'b1;
          if (fetch_stop_s) begin
            pc_s = pc_r;
          end else begin
            pc_s = pc_r + 16'd1;
          end
        end
      end
      HALTED: begin
        dec_valid_s = 1'b0;
        halted_s    = 1'b1;
      end
      default: begin
        state_s     = START;
        pc_s        = RESET_PC;
        dec_valid_s = 1'b0;
        halted_s    = 1'b0;
      end
    endcase
  end

  // State and datapath registers; reset abandons everything immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= START;
      pc_r        <= RESET_PC;
      dec_r       <= 9'd0;
      dec_valid_r <= 1'b0;
      halted_r    <= 1'b0;
    end else begin
      state_r     <= state_s;
      pc_r        <= pc_s;
      dec_r       <= dec_s;
      dec_valid_r <= dec_valid_s;
      halted_r    <= halted_s;
    end
  end

`ifdef FDU_ILLEGAL_TRAP_EN
  // Sticky illegal-trap flag, cleared only by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      trap_r <= 1'b0;
    end else begin
      trap_r <= trap_s;
    end
  end

  assign bus.illegal = trap_r | (dec_valid_r & op_is_illegal(dec_r[8:4]));
`else
  assign bus.illegal = 1'b0;
`endif

  assign bus.pc        = pc_r;
  assign bus.opcode    = dec_r[8:4];
  assign bus.operand   = dec_r[3:0];
  assign bus.dec_valid = dec_valid_r;
  assign bus.halted    = halted_r;
  assign bus.is_branch = dec_valid_r & op_is_branch(dec_r[8:4]);
  assign bus.is_mem    = dec_valid_r & op_is_mem(dec_r[8:4]);

endmodule

// File: doc/fetch_decode_unit.md
FETCH_DECODE_UNIT -- requirements
Module: fetch_decode_unit

Interface
REQ-001 The block SHALL have the parameter RESET_PC, default 16'd1, which is the first fetch address after reset.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: the reset, asynchronous and active-low.
REQ-004 The block SHALL have port pc, output, 16 bits: the fetch address driven to the instruction ROM.
REQ-005 The block SHALL have port instruction, input, 9 bits: the ROM word for the current pc, combinational from pc.
REQ-006 The block SHALL have port stall, input, 1 bit: when high, pc and the decode register hold.
REQ-007 The block SHALL have port redirect, input, 1 bit: a taken branch or jump from execute.
REQ-008 The block SHALL have port redirect_pc, input, 16 bits: the target address used when redirect is high.
REQ-009 The block SHALL have port opcode, output, 5 bits: bits [8:4] of the registered instruction.
REQ-010 The block SHALL have port operand, output, 4 bits: bits [3:0] of the registered instruction.
REQ-011 The block SHALL have port dec_valid, output, 1 bit: opcode and operand hold a live instruction.
REQ-012 The block SHALL have port is_branch, output, 1 bit: the decoded opcode is in 5'b01111..5'b10011 or equals 5'b11000 (jump).
REQ-013 The block SHALL have port is_mem, output, 1 bit: the decoded opcode is 5'b10110 (ld) or 5'b10111 (st).
REQ-014 The block SHALL have port halted, output, 1 bit: halt (5'b11010) has been retired and fetch is stopped.
REQ-015 The block SHALL have port illegal, output, 1 bit: the decoded opcode is in 5'b11011..5'b11111.

Function
REQ-016 The FSM SHALL have the states START, RUN and HALTED.
REQ-017 In START, pc SHALL equal RESET_PC, dec_valid SHALL be 0, and the next state SHALL be RUN.
REQ-018 In RUN with stall=0 and redirect=0, the decode register SHALL load instruction, dec_valid SHALL go to 1, and pc SHALL go to pc+1.
REQ-019 The latency from pc=N to the word at N appearing on opcode/operand SHALL be exactly one cycle.
REQ-020 pc SHALL wrap from 16'hFFFF to 16'h0000 with no flag.
REQ-021 In RUN with stall=1 and redirect=0, pc, the decode register and dec_valid SHALL hold unchanged.
REQ-022 redirect=1 in RUN SHALL take priority over stall: pc SHALL load redirect_pc, dec_valid SHALL go to 0 on the next cycle (flush), and the fetched instruction SHALL be discarded.
REQ-023 When halt is loaded into the decode register with no redirect, the following cycle SHALL present it with dec_valid=1, pc SHALL stop incrementing from that load onward, and the state SHALL go to HALTED.
REQ-024 In HALTED, dec_valid SHALL be 0 from the cycle after halt was presented, halted SHALL be 1, and pc SHALL be frozen.
REQ-025 In HALTED, stall and redirect SHALL be ignored; only reset leaves HALTED.
REQ-026 If redirect is high in the same cycle a halt is presented, redirect SHALL win, the halt SHALL be squashed, and the block SHALL stay in RUN.
REQ-027 is_branch, is_mem and illegal SHALL be combinational from the decode register and SHALL be gated by dec_valid, so they read 0 when dec_valid=0.

Reset
REQ-028 While rst_n=0, the block SHALL asynchronously hold pc=RESET_PC, opcode=0, operand=0, dec_valid=0, halted=0, illegal=0 and state=START.
REQ-029 Reset asserted mid-operation, including in HALTED, SHALL abandon all state immediately.
REQ-030 After rst_n rises, the first valid instruction SHALL appear two edges later.

Configuration
REQ-031 With FDU_ILLEGAL_TRAP_EN defined, an illegal opcode presented with dec_valid=1 SHALL behave as halt (enter HALTED), and illegal SHALL stay 1 until reset.
REQ-032 Without FDU_ILLEGAL_TRAP_EN, an illegal opcode SHALL pass as a no-op (dec_valid=1, is_branch=0, is_mem=0), illegal SHALL be tied 0, and fetch SHALL continue.

Verification
REQ-033 Release reset with a ROM model: pc=1 then 2, 3, ...; opcode/operand at cycle k+1 SHALL equal ROM[pc at cycle k]; dec_valid=1 from the second edge onward.
REQ-034 Hold stall for 3 cycles at pc=5: pc SHALL stay 5, opcode SHALL hold the word at 4, and the sequence SHALL resume at 5 with nothing lost or duplicated.
REQ-035 Pulse redirect with redirect_pc=16'h0040 while stall=1 at pc=9: next pc SHALL be 0x40, dec_valid SHALL be 0 for one cycle, then opcode SHALL be ROM[0x40].
REQ-036 Put halt at address 81: opcode SHALL be 5'b11010 with dec_valid=1 for one cycle, then halted=1 and dec_valid=0, with pc frozen for 20 cycles despite redirect pulses.
REQ-037 Put 5'b11011 at address 3: with FDU_ILLEGAL_TRAP_EN, illegal=1 and halted=1 SHALL follow; without it, illegal=0 and pc SHALL continue to 4, 5.
REQ-038 Assert rst_n=0 mid-cycle while HALTED: outputs SHALL drop to reset values without waiting for a clock edge.
